iob_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single IOB master port between the pipelined CPU's instruction-fetch port (port 0) and data-memory port (port 1). It accepts one transaction at a time, holds the grant until the memory side answers, and returns a registered one-cycle `ready` with read data or an error flag to the winner. A watchdog aborts transactions the memory never acknowledges. It sits between the CPU ports and the IOB memory/peripheral interconnect.

---
 rtl/iob_arb_pkg.sv | 14 +
 rtl/iob_arb_watchdog.sv | 32 +++
 rtl/iob_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_iob_mem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/iob_arb_pkg.sv
// Shared types for the IOB memory arbiter.
// FSM encoding and requester port indices.
package iob_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/iob_arb_watchdog.sv
// Saturating cycle counter that flags a stalled memory transaction.
// TIMEOUT of zero keeps expire permanently low.
module iob_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [W-1:0] LIMIT = W'(LIM_I);
    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != MAX) begin
            count <= count + W'(1);
        end
    end

    assign expire = (TIMEOUT != 0) && (count == LIMIT);

endmodule

// File: rtl/iob_mem_arbiter.sv
// Round-robin arbiter sharing one IOB master between ifetch and data ports.
// One transaction in flight; every output is registered.
module iob_mem_arbiter
    import iob_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid_i,
    input  logic [2*ADDR_W-1:0]   req_addr_i,
    input  logic [2*DATA_W-1:0]   req_wdata_i,
    input  logic [2*DATA_W/8-1:0] req_wstrb_i,
    output logic [1:0]            req_ready_o,
    output logic [DATA_W-1:0]     req_rdata_o,
    output logic                  req_err_o,
    output logic                  iob_valid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    input  logic [DATA_W-1:0]     iob_rdata_i
);

    localparam int SW = DATA_W / 8;

    state_t            state, state_n;
    logic              grant, grant_n;
    logic              last, last_n;
    logic              win;
    logic              valid_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic [SW-1:0]     wstrb_n;
    logic [1:0]        ready_n;
    logic [DATA_W-1:0] rdata_n;
    logic              err_n;
    logic              wd_clear;
    logic              wd_en;
    logic              wd_expire;

    iob_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wd (
        .clk   (clk),
        .reset (reset),
        .clear (wd_clear),
        .enable(wd_en),
        .expire(wd_expire)
    );

    // On a tie, the port that did not win last time goes next.
    always_comb begin
        case (req_valid_i)
            2'b01:   win = PORT_IF;
            2'b10:   win = PORT_DM;
            2'b11:   win = (last == PORT_IF) ? PORT_DM : PORT_IF;
            default: win = PORT_IF;
        endcase
    end

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        last_n   = last;
        valid_n  = iob_valid_o;
        addr_n   = iob_addr_o;
        wdata_n  = iob_wdata_o;
        wstrb_n  = iob_wstrb_o;
        ready_n  = 2'b00;
        rdata_n  = req_rdata_o;
        err_n    = req_err_o;
        wd_clear = 1'b0;
        wd_en    = 1'b0;
        unique case (state)
            IDLE: begin
                if (|req_valid_i) begin
                    grant_n  = win;
                    valid_n  = 1'b1;
                    wd_clear = 1'b1;
                    state_n  = ACTIVE;
                    if (win == PORT_DM) begin
                        addr_n  = req_addr_i[2*ADDR_W-1:ADDR_W];
                        wdata_n = req_wdata_i[2*DATA_W-1:DATA_W];
                        wstrb_n = req_wstrb_i[2*SW-1:SW];
                    end else begin
                        addr_n  = req_addr_i[ADDR_W-1:0];
                        wdata_n = req_wdata_i[DATA_W-1:0];
                        wstrb_n = req_wstrb_i[SW-1:0];
                    end
                end
            end
            ACTIVE: begin
                if (iob_ready_i) begin
                    valid_n        = 1'b0;
                    rdata_n        = iob_rdata_i;
                    err_n          = 1'b0;
                    ready_n[grant] = 1'b1;
                    state_n        = RESP;
                end else if (wd_expire) begin
                    valid_n        = 1'b0;
                    rdata_n        = '0;
                    err_n          = 1'b1;
                    ready_n[grant] = 1'b1;
                    state_n        = RESP;
                end else begin
                    wd_en = 1'b1;
                end
            end
            RESP: begin
                last_n  = grant;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant       <= PORT_IF;
            last        <= PORT_DM;
            iob_valid_o <= 1'b0;
            iob_addr_o  <= '0;
            iob_wdata_o <= '0;
            iob_wstrb_o <= '0;
            req_ready_o <= 2'b00;
            req_rdata_o <= '0;
            req_err_o   <= 1'b0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            last        <= last_n;
            iob_valid_o <= valid_n;
            iob_addr_o  <= addr_n;
            iob_wdata_o <= wdata_n;
            iob_wstrb_o <= wstrb_n;
            req_ready_o <= ready_n;
            req_rdata_o <= rdata_n;
            req_err_o   <= err_n;
        end
    end

endmodule

// File: tb/tb_iob_mem_arbiter.sv
// Directed self-checking bench for iob_mem_arbiter (TIMEOUT=4).
// Drives and samples on the falling clock edge.
module tb_iob_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    req_valid_i = '0;
    logic [2*AW-1:0] req_addr_i = '0;
    logic [2*DW-1:0] req_wdata_i = '0;
    logic [7:0]    req_wstrb_i = '0;
    logic [1:0]    req_ready_o;
    logic [DW-1:0] req_rdata_o;
    logic          req_err_o;
    logic          iob_valid_o;
    logic [AW-1:0] iob_addr_o;
    logic [DW-1:0] iob_wdata_o;
    logic [3:0]    iob_wstrb_o;
    logic          iob_ready_i = 1'b0;
    logic [DW-1:0] iob_rdata_i = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iob_mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid_i(req_valid_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .req_wstrb_i(req_wstrb_i),
        .req_ready_o(req_ready_o),
        .req_rdata_o(req_rdata_o),
        .req_err_o  (req_err_o),
        .iob_valid_o(iob_valid_o),
        .iob_addr_o (iob_addr_o),
        .iob_wdata_o(iob_wdata_o),
        .iob_wstrb_o(iob_wstrb_o),
        .iob_ready_i(iob_ready_i),
        .iob_rdata_i(iob_rdata_i)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset       = 1'b0;
        req_valid_i = '0;
        iob_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the first ACTIVE negedge, or flags a stalled grant.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!iob_valid_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_grant"}, 64'(iob_valid_o), 64'd1);
    endtask

    // Hold off the ack for waits cycles, then ack once; ends in RESP.
    task automatic serve(input int waits, input logic [31:0] data);
        repeat (waits) @(negedge clk);
        iob_ready_i = 1'b1;
        iob_rdata_i = data;
        @(negedge clk);
        iob_ready_i = 1'b0;
        iob_rdata_i = '0;
    endtask

    initial begin : main
        int cnt0;
        int cnt1;
        int hi;

        // Reset values
        @(negedge clk);
        check("rst_valid", 64'(iob_valid_o), 64'd0);
        check("rst_addr", 64'(iob_addr_o), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd0);
        check("rst_rdata", 64'(req_rdata_o), 64'd0);
        check("rst_err", 64'(req_err_o), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Port 1 write with two wait states
        req_valid_i = 2'b10;
        req_addr_i  = {32'h0000_0100, 32'h0};
        req_wdata_i = {32'hDEAD_BEEF, 32'h0};
        req_wstrb_i = 8'hF0;
        @(negedge clk);
        check("wr_valid", 64'(iob_valid_o), 64'd1);
        check("wr_addr", 64'(iob_addr_o), 64'h100);
        check("wr_wdata", 64'(iob_wdata_o), 64'hDEADBEEF);
        check("wr_wstrb", 64'(iob_wstrb_o), 64'hF);
        check("wr_noready", 64'(req_ready_o), 64'd0);
        serve(2, 32'h1234_5678);
        check("wr_ready", 64'(req_ready_o), 64'b10);
        check("wr_err", 64'(req_err_o), 64'd0);
        check("wr_rdata", 64'(req_rdata_o), 64'h12345678);
        check("wr_vdrop", 64'(iob_valid_o), 64'd0);
        req_valid_i = '0;
        req_wstrb_i = '0;
        @(negedge clk);
        check("wr_pulse1", 64'(req_ready_o), 64'd0);

        // Tie from reset: port 0 first
        apply_reset();
        req_valid_i = 2'b11;
        req_addr_i  = {32'h0000_0040, 32'h0};
        @(negedge clk);
        check("tie_addr0", 64'(iob_addr_o), 64'h0);
        serve(0, 32'h1111_1111);
        check("tie_rdy0", 64'(req_ready_o), 64'b01);
        check("tie_rd0", 64'(req_rdata_o), 64'h11111111);
        req_valid_i = 2'b10;
        wait_valid("tie1");
        check("tie_addr1", 64'(iob_addr_o), 64'h40);
        serve(0, 32'h2222_2222);
        check("tie_rdy1", 64'(req_ready_o), 64'b10);
        check("tie_rd1", 64'(req_rdata_o), 64'h22222222);
        req_valid_i = '0;
        @(negedge clk);

        // Both streaming: strict alternation
        apply_reset();
        req_valid_i = 2'b11;
        cnt0 = 0;
        cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            wait_valid("rr");
            check("rr_addr", 64'(iob_addr_o),
                  (i % 2 == 0) ? 64'h0 : 64'h40);
            serve(i % 2, 32'hA000_0000 + 32'(i));
            check("rr_grant", 64'(req_ready_o),
                  (i % 2 == 0) ? 64'b01 : 64'b10);
            if (req_ready_o == 2'b01) cnt0++;
            if (req_ready_o == 2'b10) cnt1++;
            @(negedge clk);
            check("rr_single", 64'(req_ready_o), 64'd0);
        end
        check("rr_cnt0", 64'(cnt0), 64'd3);
        check("rr_cnt1", 64'(cnt1), 64'd3);
        req_valid_i = '0;
        @(negedge clk);

        // Timeout: no ack ever
        req_valid_i = 2'b01;
        req_addr_i  = {32'h0, 32'h0000_0080};
        wait_valid("to");
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            if (iob_valid_o) hi++;
            if (req_ready_o != 2'b00) break;
            @(negedge clk);
        end
        check("to_cycles", 64'(hi), 64'd4);
        check("to_ready", 64'(req_ready_o), 64'b01);
        check("to_err", 64'(req_err_o), 64'd1);
        check("to_rdata", 64'(req_rdata_o), 64'd0);
        req_valid_i = '0;
        @(negedge clk);

        // Ack on the last ACTIVE cycle beats the timeout
        req_valid_i = 2'b01;
        wait_valid("edge");
        serve(3, 32'hCAFE_F00D);
        check("edge_ready", 64'(req_ready_o), 64'b01);
        check("edge_err", 64'(req_err_o), 64'd0);
        check("edge_rdata", 64'(req_rdata_o), 64'hCAFEF00D);
        req_valid_i = '0;
        @(negedge clk);

        // Reset mid-transaction
        req_valid_i = 2'b01;
        wait_valid("mid");
        reset = 1'b0;
        #1;
        check("mid_vdrop", 64'(iob_valid_o), 64'd0);
        req_valid_i = '0;
        @(negedge clk);
        reset = 1'b1;
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (req_ready_o != 2'b00) hi++;
        end
        check("mid_noready", 64'(hi), 64'd0);
        req_valid_i = 2'b01;
        req_addr_i  = {32'h0, 32'h0000_0004};
        wait_valid("post");
        check("post_addr", 64'(iob_addr_o), 64'h4);
        serve(1, 32'h55AA_55AA);
        check("post_ready", 64'(req_ready_o), 64'b01);
        check("post_err", 64'(req_err_o), 64'd0);
        check("post_rdata", 64'(req_rdata_o), 64'h55AA55AA);
        req_valid_i = '0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
